decimal_entry_ctrl: RTL and testbench

DECIMAL_ENTRY_CTRL -- requirements
Module: decimal_entry_ctrl

---
 rtl/decimal_entry_ctrl_pkg.sv | 22 ++
 rtl/decimal_entry_ctrl_button_debounce.sv | 51 +++++
 rtl/decimal_entry_ctrl.sv | 120 ++++++++++++
 tb/tb_decimal_entry_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/decimal_entry_ctrl_pkg.sv
// Shared constants, FSM encoding and 52-bit staging layout for the decimal entry controller.
package decimal_entry_ctrl_pkg;

  localparam int NIBBLES = 13;
  localparam int BCD_MAX = 9;
  localparam int BUF_W   = 4 * NIBBLES;

  // Staging buffer field positions: first-entered nibble lands in the sign field.
  localparam int SIGN_MSB = 51;
  localparam int SIGN_LSB = 48;
  localparam int INT_MSB  = 47;
  localparam int INT_LSB  = 24;
  localparam int FRAC_MSB = 23;
  localparam int FRAC_LSB = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/decimal_entry_ctrl_button_debounce.sv
// Two-FF synchronizer, stability debouncer and single-cycle press pulse for one raw button.
module button_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic pulse
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic          meta_q, sync_q, sync_d;
  logic [CW-1:0] cnt_q;
  logic          db_q;
  logic          armed_q;
  logic          stable;

  // True on every clock the synchronized level has held for DB_CYCLES clocks.
  assign stable = (cnt_q == LAST) && (sync_q == sync_d);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      sync_d  <= 1'b0;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      armed_q <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      meta_q <= button;
      sync_q <= meta_q;
      sync_d <= sync_q;
      if (sync_q != sync_d)
        cnt_q <= '0;
      else if (cnt_q != LAST)
        cnt_q <= cnt_q + 1'b1;
      if (stable) begin
        db_q <= sync_q;
        // Arm only after a stable low, so a button held through reset stays silent.
        if (!sync_q)
          armed_q <= 1'b1;
      end
      pulse <= stable && sync_q && !db_q && armed_q;
    end
  end

endmodule

// File: rtl/decimal_entry_ctrl.sv
// Decimal entry FSM: stages up to 13 BCD nibbles from debounced buttons and commits them on demand.
module decimal_entry_ctrl
  import decimal_entry_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  sw,
  input  logic        button_up,
  input  logic        button_down,
  output logic [3:0]  sign,
  output logic [23:0] int_val_6,
  output logic [23:0] frac_val_6,
  output logic [3:0]  digit_cnt,
  output logic        full,
  output logic        err,
  output logic        done
);

  logic             up_p, down_p;
  logic             up_only, down_only;
  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [BUF_W-1:0] stage_q, stage_d;
  logic             commit, err_d;

  button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
    .clk    (clk),
    .rst    (rst),
    .button (button_up),
    .pulse  (up_p)
  );

  button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_down (
    .clk    (clk),
    .rst    (rst),
    .button (button_down),
    .pulse  (down_p)
  );

  // Simultaneous up and down cancel each other.
  assign up_only   = up_p & ~down_p;
  assign down_only = down_p & ~up_p;

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    commit  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE, ENTRY: begin
        if (up_only) begin
          if (sw <= 4'(BCD_MAX)) begin
            stage_d = {stage_q[BUF_W-5:0], sw};
            cnt_d   = cnt_q + 4'd1;
            state_d = (cnt_q == 4'(NIBBLES - 1)) ? FULL : ENTRY;
          end else begin
            err_d = 1'b1;
          end
        end else if (down_only) begin
          if (state_q == IDLE) begin
            err_d = 1'b1;
          end else begin
            stage_d = {4'h0, stage_q[BUF_W-1:4]};
            cnt_d   = cnt_q - 4'd1;
            state_d = (cnt_q == 4'd1) ? IDLE : ENTRY;
          end
        end
      end
      FULL: begin
        if (up_only) begin
          commit  = 1'b1;
          stage_d = '0;
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else if (down_only) begin
          stage_d = {4'h0, stage_q[BUF_W-1:4]};
          cnt_d   = cnt_q - 4'd1;
          state_d = ENTRY;
        end
      end
      default: begin
        stage_d = '0;
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      stage_q    <= '0;
      sign       <= 4'h0;
      int_val_6  <= 24'h0;
      frac_val_6 <= 24'h0;
      err        <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      err     <= err_d;
      done    <= commit;
      if (commit) begin
        sign       <= stage_q[SIGN_MSB:SIGN_LSB];
        int_val_6  <= stage_q[INT_MSB:INT_LSB];
        frac_val_6 <= stage_q[FRAC_MSB:FRAC_LSB];
      end
    end
  end

  assign full      = (state_q == FULL);
  assign digit_cnt = cnt_q;

endmodule

// File: tb/tb_decimal_entry_ctrl.sv
// Directed bench for decimal_entry_ctrl with a short debounce window.
module tb_decimal_entry_ctrl;
  import decimal_entry_ctrl_pkg::*;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  sw;
  logic        button_up, button_down;
  logic [3:0]  sign;
  logic [23:0] int_val_6, frac_val_6;
  logic [3:0]  digit_cnt;
  logic        full, err, done;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int done_seen = 0;
  int err_base, done_base;

  decimal_entry_ctrl #(.DB_CYCLES(DB)) dut (
    .clk         (clk),
    .rst         (rst),
    .sw          (sw),
    .button_up   (button_up),
    .button_down (button_down),
    .sign        (sign),
    .int_val_6   (int_val_6),
    .frac_val_6  (frac_val_6),
    .digit_cnt   (digit_cnt),
    .full        (full),
    .err         (err),
    .done        (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (err)  err_seen++;
    if (done) done_seen++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_up(input logic [3:0] d);
    sw = d;
    button_up = 1'b1;
    cycles(12);
    button_up = 1'b0;
    cycles(12);
  endtask

  task automatic press_down();
    button_down = 1'b1;
    cycles(12);
    button_down = 1'b0;
    cycles(12);
  endtask

  logic [3:0] seq_a [13] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2, 4'd3};
  logic [3:0] seq_b [13] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};

  initial begin
    rst = 1'b0;
    sw = 4'h0;
    button_up = 1'b0;
    button_down = 1'b0;
    cycles(3);
    rst = 1'b1;
    cycles(10);

    check("rst_outputs", {sign, int_val_6, frac_val_6}, 52'h0);
    check("rst_cnt", digit_cnt, 4'd0);
    check("rst_full", full, 1'b0);

    // Full 13-nibble entry and commit.
    for (int i = 0; i < 13; i++) press_up(seq_a[i]);
    check("fill_cnt", digit_cnt, 4'd13);
    check("fill_full", full, 1'b1);
    done_base = done_seen;
    err_base = err_seen;
    press_up(4'hF);
    check("commit_done", done_seen - done_base, 1);
    check("commit_no_err", err_seen - err_base, 0);
    check("commit_sign", sign, 4'h1);
    check("commit_int", int_val_6, 24'h234567);
    check("commit_frac", frac_val_6, 24'h890123);
    check("commit_cnt", digit_cnt, 4'd0);
    check("commit_full", full, 1'b0);

    // Backspace in the middle of an entry.
    press_up(4'd5);
    press_up(4'd7);
    press_down();
    press_up(4'd9);
    check("bs_cnt", digit_cnt, 4'd2);
    check("bs_stage", dut.stage_q[7:0], 8'h59);
    check("bs_outputs", {sign, int_val_6, frac_val_6}, {4'h1, 24'h234567, 24'h890123});

    // Rejected entries from IDLE.
    press_down();
    press_down();
    check("idle_cnt", digit_cnt, 4'd0);
    err_base = err_seen;
    press_up(4'hA);
    check("bad_digit_err", err_seen - err_base, 1);
    check("bad_digit_cnt", digit_cnt, 4'd0);
    err_base = err_seen;
    press_down();
    check("idle_down_err", err_seen - err_base, 1);
    check("idle_down_cnt", digit_cnt, 4'd0);

    // Bounce shorter than the window, then a real hold.
    err_base = err_seen;
    sw = 4'd3;
    button_up = 1'b1;
    cycles(3);
    button_up = 1'b0;
    cycles(12);
    check("bounce_ignored", digit_cnt, 4'd0);
    button_up = 1'b1;
    cycles(10);
    button_up = 1'b0;
    cycles(12);
    check("bounce_cnt", digit_cnt, 4'd1);
    check("bounce_stage", dut.stage_q[3:0], 4'd3);

    // Both buttons together cancel.
    err_base = err_seen;
    sw = 4'd6;
    button_up = 1'b1;
    button_down = 1'b1;
    cycles(12);
    button_up = 1'b0;
    button_down = 1'b0;
    cycles(12);
    check("both_cnt", digit_cnt, 4'd1);
    check("both_no_err", err_seen - err_base, 0);

    // Commit 000001, then reset with 7 nibbles staged and a held button.
    press_down();
    for (int i = 0; i < 13; i++) press_up(seq_b[i]);
    press_up(4'h0);
    check("commit2_int", int_val_6, 24'h000001);
    for (int i = 1; i <= 7; i++) press_up(4'(i));
    check("pre_rst_cnt", digit_cnt, 4'd7);
    rst = 1'b0;
    #1;
    check("rst_mid_outputs", {sign, int_val_6, frac_val_6}, 52'h0);
    check("rst_mid_cnt", digit_cnt, 4'd0);
    check("rst_mid_state", dut.state_q, IDLE);
    check("rst_mid_pulses", {err, done, full}, 3'b000);
    button_up = 1'b1;
    sw = 4'd8;
    cycles(3);
    rst = 1'b1;
    err_base = err_seen;
    done_base = done_seen;
    cycles(20);
    button_up = 1'b0;
    cycles(12);
    check("held_no_entry", digit_cnt, 4'd0);
    check("held_no_pulse", (err_seen - err_base) + (done_seen - done_base), 0);
    press_up(4'd5);
    check("rearm_cnt", digit_cnt, 4'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
